dummy_soc: RTL and testbench
============================

// Module: dummy_soc
// PURPOSE
// - Minimal top-level SoC for the iCE board: receives bytes from the iCE-link USB-UART
//   bridge on icelink_rx (8N1) and latches the last good byte onto the board LEDs.
// - Contains a power-on reset generator, a UART receiver and a status register.
// - Optional transmit-echo path on icelink_tx.
// - Top of the FPGA hierarchy. No bus, no CPU.
// PARAMETERS
// - CLK_HZ  `FCLK (default 12_000_000)  board_clock frequency in Hz.
// - BAUD    `BAUDS (default 115_200)    UART bit rate.
// - DIV     CLK_HZ/BAUD (derived, integer, truncated)  clocks per bit; must be >= 8.
// - POR_CYC 16                          power-on reset length in clocks.
// PORTS
// - board_clock  in   1  single system clock; all logic on its rising edge.
// - reset        --   1  internal signal, not a port: synchronous, active-high, from POR counter.
// - icelink_rx   in   1  UART RX, idle high, asynchronous to board_clock.
// - icelink_tx   out  1  UART TX, idle high. Used only with echo; otherwise tied 1.
// - led          out  8  last byte received with a valid stop bit.
// - frame_err    out  1  sticky: a received byte had a low stop bit.
// BEHAVIOUR
// Clock and reset:
// - One clock: board_clock.
// - Reset: synchronous, active-high.
// - POR: 5-bit counter, 0 after configuration. reset=1 while count<POR_CYC; then reset=0 permanently.
// - While reset=1: led=0, frame_err=0, icelink_tx=1, RX FSM=IDLE, internal counters=0.
// RX input:
// - icelink_rx passes through a 2-FF synchronizer (preset to 1 on reset) before use.
// RX FSM (IDLE, START, DATA, STOP), bit counter cnt runs 0..DIV-1:
// - IDLE: wait for synchronized rx==0 -> START, cnt=0.
// - START: at cnt==DIV/2-1 sample. rx==1 -> glitch, back to IDLE. rx==0 -> DATA, cnt=0, bit=0.
// - DATA: at each cnt==DIV-1 (mid-bit) shift rx into data[7] with right shift, so the byte lands LSB first.
//   After bit 7 -> STOP.
// - STOP: at cnt==DIV-1 sample stop bit.
//   - 1: rx_valid pulses for 1 cycle, led<=data on the same edge, frame_err unchanged.
//   - 0: frame_err<=1, led unchanged.
//   Either case -> IDLE.
// Timing and boundaries:
// - Latency: led updates about 9.5 bit times after the start-bit falling edge (+2 sync clocks).
// - A line held low after a framing error starts no new frame until rx has returned to 1 for one clock.
// - Back-to-back frames with no idle gap between stop and the next start are received correctly.
// - frame_err clears only on reset.
// CONFIGURATION
// - Macro ECHO_EN defined: 8N1 UART transmitter on icelink_tx, same DIV.
//   - Each rx_valid byte is loaded into a 1-byte holding register and sent.
//   - If the TX is busy and the holder is full, the new byte overwrites the holder.
//   - TX starts the clock after rx_valid: start bit, LSB first, stop bit, each DIV clocks.
// - ECHO_EN undefined: no TX logic; icelink_tx is constant 1.
// TESTING
// - Reset: first POR_CYC clocks -> led==0, frame_err==0, icelink_tx==1.
// - Byte 0x41: at 600 us drive start, then bits 1,0,0,0,0,0,1,0 (LSB first), then stop=1, each 1/BAUD.
//   -> led==8'h41 within 10 bit times; frame_err==0.
// - Glitch: rx low for DIV/4 clocks, then high -> no led change, FSM back in IDLE.
// - Framing error: send 0x5A with stop=0 -> led keeps its old value; frame_err==1 and stays 1.
// - Back-to-back bytes 0x00, 0xFF with no gap -> led==0x00, then led==0xFF.
// - ECHO_EN: send 0x41 -> icelink_tx emits 0,1,0,0,0,0,0,1,0,1 at BAUD, starting after rx_valid.

Source files
------------

// File: rtl/dummy_soc.sv
// iCE board top: POR, 8N1 UART receiver latching the last good byte onto the LEDs.
// Define ECHO_EN to echo every received byte back out on icelink_tx.
`ifndef FCLK
  `define FCLK 12_000_000
`endif
`ifndef BAUDS
  `define BAUDS 115_200
`endif

module dummy_soc #(
  parameter int CLK_HZ = `FCLK,
  parameter int BAUD   = `BAUDS
) (
  input  logic       board_clock,
  input  logic       icelink_rx,
  output logic       icelink_tx,
  output logic [7:0] led,
  output logic       frame_err,
  output logic [1:0] rx_state
);

  localparam int DIV     = CLK_HZ / BAUD;
  localparam int CW      = $clog2(DIV);
  localparam int POR_CYC = 16;
  localparam logic [CW-1:0] CNT_MAX  = CW'(DIV - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(DIV / 2 - 1);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} rx_state_t;

  // Power-on reset: the counter relies on the FPGA configuration value of 0.
  logic [4:0] por_cnt = 5'd0;
  logic       reset;

  assign reset = (por_cnt < 5'(POR_CYC));

  always_ff @(posedge board_clock) begin
    if (reset) por_cnt <= por_cnt + 5'd1;
  end

  logic rx_s1, rx_s2;

  always_ff @(posedge board_clock) begin
    if (reset) begin
      rx_s1 <= 1'b1;
      rx_s2 <= 1'b1;
    end else begin
      rx_s1 <= icelink_rx;
      rx_s2 <= rx_s1;
    end
  end

  rx_state_t     state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic [2:0]    bitn, bitn_nx;
  logic [7:0]    data, data_nx;
  logic          wait_high, wait_high_nx;
  logic          rx_valid, ferr_set;

  // wait_high blocks a new start after a framing error until the line has been seen high.
  always_comb begin
    state_nx     = state;
    cnt_nx       = cnt;
    bitn_nx      = bitn;
    data_nx      = data;
    wait_high_nx = wait_high & ~rx_s2;
    rx_valid     = 1'b0;
    ferr_set     = 1'b0;
    case (state)
      S_IDLE: begin
        if (!wait_high && !rx_s2) begin
          state_nx = S_START;
          cnt_nx   = '0;
        end
      end
      S_START: begin
        if (cnt == CNT_HALF) begin
          cnt_nx   = '0;
          bitn_nx  = 3'd0;
          state_nx = rx_s2 ? S_IDLE : S_DATA;
        end else begin
          cnt_nx = cnt + CW'(1);
        end
      end
      S_DATA: begin
        if (cnt == CNT_MAX) begin
          cnt_nx  = '0;
          data_nx = {rx_s2, data[7:1]};
          bitn_nx = bitn + 3'd1;
          if (bitn == 3'd7) state_nx = S_STOP;
        end else begin
          cnt_nx = cnt + CW'(1);
        end
      end
      S_STOP: begin
        if (cnt == CNT_MAX) begin
          cnt_nx   = '0;
          state_nx = S_IDLE;
          if (rx_s2) begin
            rx_valid = 1'b1;
          end else begin
            ferr_set     = 1'b1;
            wait_high_nx = 1'b1;
          end
        end else begin
          cnt_nx = cnt + CW'(1);
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge board_clock) begin
    if (reset) begin
      state     <= S_IDLE;
      cnt       <= '0;
      bitn      <= 3'd0;
      data      <= 8'd0;
      wait_high <= 1'b0;
      led       <= 8'd0;
      frame_err <= 1'b0;
    end else begin
      state     <= state_nx;
      cnt       <= cnt_nx;
      bitn      <= bitn_nx;
      data      <= data_nx;
      wait_high <= wait_high_nx;
      if (rx_valid) led <= data;
      if (ferr_set) frame_err <= 1'b1;
    end
  end

  assign rx_state = state;

`ifdef ECHO_EN
  logic [7:0]    hold;
  logic          hold_full;
  logic          tx_busy;
  logic [9:0]    tx_frame;
  logic [3:0]    tx_bits;
  logic [CW-1:0] tx_cnt;

  // tx_frame is {stop, data, start}, shifted out LSB first; a new rx byte overwrites the holder.
  always_ff @(posedge board_clock) begin
    if (reset) begin
      hold      <= 8'd0;
      hold_full <= 1'b0;
      tx_busy   <= 1'b0;
      tx_frame  <= '1;
      tx_bits   <= 4'd0;
      tx_cnt    <= '0;
    end else begin
      if (!tx_busy && hold_full) begin
        tx_busy   <= 1'b1;
        tx_frame  <= {1'b1, hold, 1'b0};
        tx_bits   <= 4'd0;
        tx_cnt    <= '0;
        hold_full <= 1'b0;
      end else if (tx_busy) begin
        if (tx_cnt == CNT_MAX) begin
          tx_cnt   <= '0;
          tx_frame <= {1'b1, tx_frame[9:1]};
          if (tx_bits == 4'd9) tx_busy <= 1'b0;
          else                 tx_bits <= tx_bits + 4'd1;
        end else begin
          tx_cnt <= tx_cnt + CW'(1);
        end
      end
      if (rx_valid) begin
        hold      <= data;
        hold_full <= 1'b1;
      end
    end
  end

  assign icelink_tx = tx_busy ? tx_frame[0] : 1'b1;
`else
  assign icelink_tx = 1'b1;
`endif

endmodule

// File: tb/tb_dummy_soc.sv
// Bench for dummy_soc: UART frames driven bit by bit, expected LED bytes checked
// through a scoreboard queue; echo framing checked when ECHO_EN is defined.
module tb_dummy_soc;

  localparam int DIV     = 104;   // 12 MHz / 115200, truncated
  localparam int POR_CYC = 16;

  logic       clk = 1'b0;
  logic       rx  = 1'b1;
  logic       tx;
  logic [7:0] led;
  logic       frame_err;
  logic [1:0] rx_state;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  dummy_soc dut (
    .board_clock(clk),
    .icelink_rx (rx),
    .icelink_tx (tx),
    .led        (led),
    .frame_err  (frame_err),
    .rx_state   (rx_state)
  );

  int         tests = 0;
  int         fails = 0;
  logic [7:0] exp_q[$];
  logic [7:0] led_prev = 8'd0;
  bit         mon_en = 1'b0;
  int         last_pop_cyc = -1;
  int         tx_low_cnt = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drive_bit(input logic b);
    rx = b;
    wait_clk(DIV);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    drive_bit(stop);
  endtask

  task automatic send_good(input logic [7:0] b);
    exp_q.push_back(b);
    send_frame(b, 1'b1);
  endtask

  task automatic wait_drain(input string tag, input int budget);
    int n = 0;
    while (exp_q.size() > 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(tag, exp_q.size(), 0);
  endtask

  task automatic tx_capture(input logic [7:0] b);
`ifdef ECHO_EN
    logic [9:0] f;
    int n = 0;
    f = {1'b1, b, 1'b0};
    while (tx !== 1'b0 && n < 12 * DIV) begin
      @(negedge clk);
      n++;
    end
    check("tx_start_seen", (n < 12 * DIV) ? 1 : 0, 1);
    wait_clk(DIV / 2);
    for (int i = 0; i < 10; i++) begin
      check($sformatf("tx_bit%0d", i), tx, f[i]);
      wait_clk(DIV);
    end
`else
    if (b != 8'h00) wait_clk(12 * DIV);
`endif
  endtask

  // Scoreboard: every LED change must match the oldest expected byte.
  always @(negedge clk) begin
    if (mon_en && led !== led_prev) begin
      if (exp_q.size() > 0) begin
        check("led", led, exp_q.pop_front());
        last_pop_cyc = cyc;
      end else begin
        check("led_unexpected", led, led_prev);
      end
      led_prev = led;
    end
  end

  always @(negedge clk) begin
    if (tx !== 1'b1) tx_low_cnt++;
  end

  initial begin
    int         start;
    logic [7:0] b;
    logic [7:0] last_b;

    rx = 1'b1;
    wait_clk(2);
    check("rst_led", led, 8'h00);
    check("rst_frame_err", frame_err, 0);
    check("rst_tx", tx, 1);
    check("rst_state", rx_state, 0);
    wait_clk(POR_CYC);
    check("por_led", led, 8'h00);
    led_prev = 8'h00;
    mon_en   = 1'b1;

    // First byte at 600 us (7200 clocks at 12 MHz).
    while (cyc < 7200) @(negedge clk);
    start = cyc;
    send_good(8'h41);
    wait_drain("b41_drain", 10 * DIV);
    check("b41_latency", (last_pop_cyc > start && last_pop_cyc - start <= 10 * DIV) ? 1 : 0, 1);
    check("b41_frame_err", frame_err, 0);
    wait_clk(DIV);

    rx = 1'b0;
    wait_clk(DIV / 4);
    rx = 1'b1;
    wait_clk(DIV);
    check("glitch_state", rx_state, 0);
    check("glitch_led", led, 8'h41);
    check("glitch_frame_err", frame_err, 0);

    // Bad stop bit, then the line stays low for three more bit times.
    send_frame(8'h5A, 1'b0);
    wait_clk(3 * DIV);
    check("ferr_low_state", rx_state, 0);
    rx = 1'b1;
    wait_clk(4);
    check("ferr_state", rx_state, 0);
    check("ferr_set", frame_err, 1);
    check("ferr_led", led, 8'h41);
    wait_clk(2 * DIV);

    send_good(8'h00);
    send_good(8'hFF);
    wait_drain("b2b_drain", 10 * DIV);
    check("ferr_sticky", frame_err, 1);
    wait_clk(12 * DIV);

    fork
      send_good(8'h41);
      tx_capture(8'h41);
    join
    wait_drain("echo_drain", 10 * DIV);
    last_b = 8'h41;

    for (int i = 0; i < 6; i++) begin
      b = 8'($urandom_range(0, 255));
      if (b == last_b) b = b ^ 8'h01;
      send_good(b);
      last_b = b;
      wait_clk($urandom_range(0, DIV));
    end
    wait_drain("rand_drain", 12 * DIV);
    check("final_led", led, last_b);
    check("final_frame_err", frame_err, 1);
`ifndef ECHO_EN
    check("tx_always_high", tx_low_cnt, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
